// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI slave, oversampled on CLK, answering an AVR SPI master.
// A one-word transmit holding buffer feeds the tx shift register. Received words
// are presented on rx_data with a single-cycle rx_valid strobe.
module spi_slave_responder #(
  parameter int               WIDTH      = 8,
  parameter bit               CPOL       = 1'b0,
  parameter bit               CPHA       = 1'b0,
  parameter logic [WIDTH-1:0] DEFAULT_TX = 8'hFF
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             SCK,
  input  logic             nCS,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_OE,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state, state_nxt;
  logic             sck_p0, sck_p1, sck_p2;
  logic             ncs_p0, ncs_p1, ncs_p2;
  logic             mosi_p0, mosi_p1;
  logic [WIDTH-1:0] hold_data, tx_shift, rx_shift;
  logic             hold_full, reload;
  logic [CW-1:0]    bit_cnt;

  logic lead, trail, sample_edge, shift_edge, ncs_fall, ncs_rise;
  logic run, start, do_sample, word_done, load, do_shift, wr;

  // Pin synchronisers: p0/p1 are the two metastability flops, p2 is the edge-detect register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sck_p0  <= 1'b0;
      sck_p1  <= 1'b0;
      sck_p2  <= 1'b0;
      ncs_p0  <= 1'b0;
      ncs_p1  <= 1'b0;
      ncs_p2  <= 1'b0;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      sck_p0  <= SCK;
      sck_p1  <= sck_p0;
      sck_p2  <= sck_p1;
      ncs_p0  <= nCS;
      ncs_p1  <= ncs_p0;
      ncs_p2  <= ncs_p1;
      mosi_p0 <= MOSI;
      mosi_p1 <= mosi_p0;
    end
  end

  // ---- edge detection (stage p1 vs p2) ----
  // Synchronisers clear to 0, so after reset a low nCS is never seen as a fall:
  // the master has to raise and lower it again before a frame starts.
  assign lead        = (sck_p2 == CPOL) && (sck_p1 != CPOL);
  assign trail       = (sck_p2 != CPOL) && (sck_p1 == CPOL);
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;
  assign ncs_fall    = ncs_p2 && !ncs_p1;
  assign ncs_rise    = !ncs_p2 && ncs_p1;

  // nCS rise beats any SCK edge in the same cycle
  assign run       = (state == ACTIVE) && !ncs_rise;
  assign start     = (state == IDLE) && ncs_fall;
  assign do_sample = run && sample_edge;
  assign word_done = do_sample && (bit_cnt == CW'(WIDTH - 1));
  assign load      = CPHA ? (run && shift_edge && (bit_cnt == '0))
                          : (start || (run && shift_edge && reload));
  assign do_shift  = run && shift_edge && !load;
  assign wr        = tx_valid && !hold_full;

  // Frame state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Frame opens on synced nCS fall and closes on synced nCS rise
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ncs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (ncs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Holding buffer, shift registers, bit counter and user-side strobes
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hold_data   <= '0;
      hold_full   <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      bit_cnt     <= '0;
      reload      <= 1'b0;
    end else begin
      // a load always takes the buffer content from before this cycle's write
      if (load && hold_full) hold_full <= 1'b0;
      if (wr) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end

      if ((state == ACTIVE) && ncs_rise) tx_shift <= '0;
      else if (load)                     tx_shift <= hold_full ? hold_data : DEFAULT_TX;
      else if (do_shift)                 tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};

      tx_underrun <= load && !hold_full;
      rx_valid    <= word_done;

      if (do_sample) rx_shift <= {rx_shift[WIDTH-2:0], mosi_p1};
      if (word_done) rx_data  <= {rx_shift[WIDTH-2:0], mosi_p1};

      if (!run)           bit_cnt <= '0;
      else if (word_done) bit_cnt <= '0;
      else if (do_sample) bit_cnt <= bit_cnt + CW'(1);

      // in CPHA=0 the next word is loaded on the shift edge after a completed word
      if (!run)             reload <= 1'b0;
      else if (word_done)   reload <= 1'b1;
      else if (shift_edge)  reload <= 1'b0;
    end
  end

  assign MISO     = tx_shift[WIDTH-1];
  assign MISO_OE  = (state == ACTIVE);
  assign busy     = (state == ACTIVE);
  assign tx_ready = !hold_full;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: mode 0 instance plus a mode 3 instance.
`timescale 1ns/1ps
module tb_spi_slave_responder;

  localparam int H = 8;  // CLK cycles per SCK half period (SCK = CLK/16)

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       SCK = 1'b0, nCS = 1'b1, MOSI = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       MISO, MISO_OE, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] rx_data;

  logic       sck3 = 1'b1, ncs3 = 1'b1, tx_valid3 = 1'b0;
  logic       miso3, miso_oe3, tx_ready3, rx_valid3, tx_underrun3, busy3;
  logic [7:0] rx_data3;

  spi_slave_responder #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .DEFAULT_TX(8'hFF)) u_dut (
    .CLK(CLK), .nRST(nRST), .SCK(SCK), .nCS(nCS), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
  );

  spi_slave_responder #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .DEFAULT_TX(8'hFF)) u_dut3 (
    .CLK(CLK), .nRST(nRST), .SCK(sck3), .nCS(ncs3), .MOSI(MOSI),
    .MISO(miso3), .MISO_OE(miso_oe3),
    .tx_data(tx_data), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
    .rx_data(rx_data3), .rx_valid(rx_valid3), .tx_underrun(tx_underrun3), .busy(busy3)
  );

  always #100 CLK = ~CLK;  // 5 MHz

  int errors = 0, checks = 0;
  int rx_cnt = 0, unr_cnt = 0, rx3_cnt = 0, unr3_cnt = 0;
  logic [7:0] rx_last = 8'h00, rx3_last = 8'h00;

  // Strobe monitor: counts every cycle a strobe is high and keeps the last word
  always @(negedge CLK) begin
    if (rx_valid)     begin rx_cnt  <= rx_cnt + 1;  rx_last  <= rx_data;  end
    if (tx_underrun)  unr_cnt  <= unr_cnt + 1;
    if (rx_valid3)    begin rx3_cnt <= rx3_cnt + 1; rx3_last <= rx_data3; end
    if (tx_underrun3) unr3_cnt <= unr3_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Write one word into the holding buffer of the mode 0 (sel=0) or mode 3 (sel=1) slave
  task automatic tx_write(input bit sel, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge CLK);
    while (!(sel ? tx_ready3 : tx_ready) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("tx_ready_wait", sel ? tx_ready3 : tx_ready, 1);
    tx_data = d;
    if (sel) tx_valid3 = 1'b1; else tx_valid = 1'b1;
    @(negedge CLK);
    tx_valid  = 1'b0;
    tx_valid3 = 1'b0;
    chk("tx_ready_drop", sel ? tx_ready3 : tx_ready, 0);
  endtask

  // Mode 0 master: MOSI changes on the falling edge, MISO read just before the rising edge
  task automatic xfer0(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mo[7-i];
      cyc(H);
      mi = {mi[6:0], MISO};
      SCK = 1'b1;
      cyc(H);
      SCK = 1'b0;
    end
    cyc(H);
  endtask

  // Mode 3 master: SCK idles high, data changes on the falling edge, sampled on the rise
  task automatic xfer3(input logic [7:0] mo, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sck3 = 1'b0;
      MOSI = mo[7-i];
      cyc(H);
      mi = {mi[6:0], miso3};
      sck3 = 1'b1;
      cyc(H);
    end
    cyc(H);
  endtask

  initial begin
    #(200 * 40000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] got;
    int         r0, u0;

    // reset values
    cyc(2);
    chk("rst_miso", MISO, 0);
    chk("rst_miso_oe", MISO_OE, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_underrun", tx_underrun, 0);
    chk("rst_busy", busy, 0);
    nRST = 1'b1;
    cyc(5);

    // single word: tx A5, rx 3C
    tx_write(0, 8'hA5);
    r0 = rx_cnt;
    nCS = 1'b0;
    cyc(H);
    chk("a_busy", busy, 1);
    chk("a_miso_oe", MISO_OE, 1);
    chk("a_tx_ready_after_load", tx_ready, 1);
    xfer0(8'h3C, 8, got);
    chk("a_miso_word", got, 8'hA5);
    chk("a_rx_pulses", rx_cnt - r0, 1);
    chk("a_rx_word", rx_last, 8'h3C);
    chk("a_rx_data", rx_data, 8'h3C);
    nCS = 1'b1;
    cyc(4);
    chk("a_busy_end", busy, 0);
    chk("a_oe_end", MISO_OE, 0);

    // back-to-back under one nCS: 12/F0 then 34/0F; a third word keeps the final reload fed
    tx_write(0, 8'h12);
    r0 = rx_cnt;
    u0 = unr_cnt;
    nCS = 1'b0;
    cyc(H);
    tx_write(0, 8'h34);
    xfer0(8'hF0, 8, got);
    chk("b_miso_w1", got, 8'h12);
    chk("b_rx_w1", rx_last, 8'hF0);
    tx_write(0, 8'h56);
    xfer0(8'h0F, 8, got);
    chk("b_miso_w2", got, 8'h34);
    chk("b_rx_w2", rx_last, 8'h0F);
    chk("b_rx_pulses", rx_cnt - r0, 2);
    chk("b_no_underrun", unr_cnt - u0, 0);
    nCS = 1'b1;
    cyc(4);
    chk("b_tx_ready_end", tx_ready, 1);

    // empty buffer at nCS fall: DEFAULT_TX with a single underrun pulse at the load
    u0 = unr_cnt;
    nCS = 1'b0;
    cyc(H);
    chk("c_underrun_pulse", unr_cnt - u0, 1);
    xfer0(8'hAA, 8, got);
    chk("c_miso_default", got, 8'hFF);
    chk("c_rx_word", rx_last, 8'hAA);
    nCS = 1'b1;
    cyc(4);

    // abort after 3 SCK cycles, then a full frame
    r0 = rx_cnt;
    nCS = 1'b0;
    cyc(H);
    xfer0(8'hC0, 3, got);
    nCS = 1'b1;
    cyc(2);
    chk("d_oe_two_cycles", MISO_OE, 1);
    cyc(1);
    chk("d_oe_three_cycles", MISO_OE, 0);
    chk("d_busy_three_cycles", busy, 0);
    cyc(4);
    chk("d_no_rx_valid", rx_cnt - r0, 0);
    tx_write(0, 8'h6B);
    nCS = 1'b0;
    cyc(H);
    xfer0(8'h96, 8, got);
    chk("d_miso_word", got, 8'h6B);
    chk("d_rx_pulses", rx_cnt - r0, 1);
    chk("d_rx_word", rx_last, 8'h96);
    nCS = 1'b1;
    cyc(4);

    // reset in mid-word with a buffered word pending
    tx_write(0, 8'h77);
    nCS = 1'b0;
    cyc(H);
    tx_write(0, 8'hE1);
    xfer0(8'h3A, 5, got);
    chk("e_miso_before_rst", MISO, 1);
    nRST = 1'b0;
    #1;
    chk("e_rst_busy", busy, 0);
    chk("e_rst_oe", MISO_OE, 0);
    chk("e_rst_miso", MISO, 0);
    chk("e_rst_tx_ready", tx_ready, 1);
    chk("e_rst_rx_data", rx_data, 8'h00);
    chk("e_rst_rx_valid", rx_valid, 0);
    chk("e_rst_underrun", tx_underrun, 0);
    cyc(2);
    nRST = 1'b1;
    cyc(4);
    r0 = rx_cnt;
    xfer0(8'hFF, 8, got);
    chk("e_held_busy", busy, 0);
    chk("e_held_oe", MISO_OE, 0);
    chk("e_held_no_rx", rx_cnt - r0, 0);
    nCS = 1'b1;
    cyc(H);
    tx_write(0, 8'hA3);
    nCS = 1'b0;
    cyc(H);
    xfer0(8'h55, 8, got);
    chk("e_miso_word", got, 8'hA3);
    chk("e_rx_word", rx_last, 8'h55);
    chk("e_rx_pulses", rx_cnt - r0, 1);
    nCS = 1'b1;
    cyc(4);

    // mode 3 instance: slave sends C3, master sends 81
    tx_write(1, 8'hC3);
    ncs3 = 1'b0;
    cyc(H);
    chk("f_busy3", busy3, 1);
    xfer3(8'h81, got);
    chk("f_miso_word", got, 8'hC3);
    chk("f_rx_word", rx3_last, 8'h81);
    chk("f_rx_data", rx_data3, 8'h81);
    chk("f_rx_pulses", rx3_cnt, 1);
    chk("f_no_underrun", unr3_cnt, 0);
    ncs3 = 1'b1;
    cyc(4);
    chk("f_oe3_end", miso_oe3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
